// File: rtl/uart_io_buffer.sv
// Byte-level 8N1 UART front end: TX FIFO feeding a serialiser, and a deserialiser
// feeding an RX FIFO, both with ready/valid handshakes toward the core.
module uart_io_buffer #(
  parameter int unsigned CLKS_PER_BIT    = 868,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] uart_in_data,
  input  logic       uart_in_valid,
  output logic       uart_in_ready,
  input  logic       uart_out_valid,
  output logic [7:0] uart_out_data,
  output logic       uart_out_ready,
  output logic       txd,
  input  logic       rxd,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       tx_busy
);
  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned AW    = FIFO_DEPTH_LOG2;
  localparam int unsigned PW    = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;

  // TX side
  logic [7:0]    tx_mem_q [DEPTH];
  logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic          tx_empty, tx_full, tx_push, tx_pop;
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          txd_q, txd_d;

  assign tx_empty      = (tx_wr_q == tx_rd_q);
  assign tx_full       = (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]) && (tx_wr_q[AW] != tx_rd_q[AW]);
  assign uart_in_ready = !tx_full;
  assign tx_push       = uart_in_valid && !tx_full;
  assign tx_busy       = !tx_empty || (tx_state_q != TX_IDLE);
  assign txd           = txd_q;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q[AW-1:0]] <= uart_in_data;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_mem_q[tx_rd_q[AW-1:0]];
          txd_d      = 1'b0;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          txd_d      = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_idx_d   = tx_idx_q + 3'd1;
            tx_shift_d = tx_shift_q >> 1;
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_mem_q[tx_rd_q[AW-1:0]];
            txd_d      = 1'b0;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    tx_wr_d = tx_wr_q + PW'(tx_push);
    tx_rd_d = tx_rd_q + PW'(tx_pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
    end
  end

  // RX side
  logic          rx_meta_q, rxs_q;
  logic [7:0]    rx_mem_q [DEPTH];
  logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic          rx_empty, rx_full, rx_pop, rx_push, rx_accept, rx_ferr_set;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_ovr_q, rx_ovr_d, rx_ferr_q, rx_ferr_d;

  assign rx_empty       = (rx_wr_q == rx_rd_q);
  assign rx_full        = (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]) && (rx_wr_q[AW] != rx_rd_q[AW]);
  assign uart_out_ready = !rx_empty;
  assign uart_out_data  = rx_empty ? 8'h00 : rx_mem_q[rx_rd_q[AW-1:0]];
  assign rx_pop         = uart_out_valid && !rx_empty;
  // A pop on the same edge frees the slot the push lands in.
  assign rx_accept      = rx_push && (!rx_full || rx_pop);
  assign rx_overrun     = rx_ovr_q;
  assign rx_frame_err   = rx_ferr_q;

  always_ff @(posedge clk) begin
    if (rx_accept) rx_mem_q[rx_wr_q[AW-1:0]] <= rx_shift_q;
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_idx_d    = rx_idx_q;
    rx_shift_d  = rx_shift_q;
    rx_push     = 1'b0;
    rx_ferr_set = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rxs_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rxs_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxs_q, rx_shift_q[7:1]};
          rx_idx_d   = rx_idx_q + 3'd1;
          if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rxs_q) begin
            rx_push    = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_ferr_set = 1'b1;
            rx_state_d  = RX_BREAK;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_BREAK: begin
        if (rxs_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
    rx_wr_d   = rx_wr_q + PW'(rx_accept);
    rx_rd_d   = rx_rd_q + PW'(rx_pop);
    rx_ovr_d  = rx_ovr_q | (rx_push && !rx_accept);
    rx_ferr_d = rx_ferr_q | rx_ferr_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rxd;
      rxs_q      <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

endmodule

// File: tb/tb_uart_io_buffer.sv
// Self-checking bench for uart_io_buffer: byte-level queue models for both FIFOs
// and a txd line decoder that rebuilds frames from the serial waveform.
module tb_uart_io_buffer;
  localparam int unsigned CPB   = 4;
  localparam int unsigned LOG2  = 2;
  localparam int unsigned DEPTH = 4;

  logic       clk;
  logic       reset;
  logic [7:0] uart_in_data;
  logic       uart_in_valid;
  logic       uart_in_ready;
  logic       uart_out_valid;
  logic [7:0] uart_out_data;
  logic       uart_out_ready;
  logic       txd;
  logic       rxd;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       tx_busy;

  uart_io_buffer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(LOG2)) dut (
    .clk            (clk),
    .reset          (reset),
    .uart_in_data   (uart_in_data),
    .uart_in_valid  (uart_in_valid),
    .uart_in_ready  (uart_in_ready),
    .uart_out_valid (uart_out_valid),
    .uart_out_data  (uart_out_data),
    .uart_out_ready (uart_out_ready),
    .txd            (txd),
    .rxd            (rxd),
    .rx_overrun     (rx_overrun),
    .rx_frame_err   (rx_frame_err),
    .tx_busy        (tx_busy)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [7:0]  tx_exp[$];
  logic [10:0] frame_q[$];
  int          gap_q[$];
  logic [7:0]  rx_model[$];
  logic        ovr_exp = 1'b0;
  logic        ferr_exp = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Decode txd: each frame is 10 bits of CPB samples; {bad, stop, data, start}.
  initial begin : tx_monitor
    int pos;
    int gap;
    logic [9:0] bits;
    logic bad;
    pos = -1; gap = 0; bits = '0; bad = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pos = -1;
        gap = 0;
      end else if (pos < 0) begin
        if (!txd) begin
          pos = 1; bits = '0; bad = 1'b0;
          gap_q.push_back(gap);
          gap = 0;
        end else begin
          gap++;
        end
      end else begin
        if (pos % CPB == 0) bits[pos / CPB] = txd;
        else if (bits[pos / CPB] != txd) bad = 1'b1;
        pos++;
        if (pos == 10 * CPB) begin
          frame_q.push_back({bad, bits});
          pos = -1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    uart_in_valid = 1'b0;
    uart_out_valid = 1'b0;
    uart_in_data = 8'h00;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    tx_exp.delete(); frame_q.delete(); gap_q.delete(); rx_model.delete();
    ovr_exp = 1'b0; ferr_exp = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] b);
    int w;
    w = 0;
    uart_in_data = b;
    uart_in_valid = 1'b1;
    while (!uart_in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("push_ready", 32'(uart_in_ready), 1);
    @(negedge clk);
    uart_in_valid = 1'b0;
    uart_in_data = 8'($urandom);
    tx_exp.push_back(b);
  endtask

  task automatic check_tx_frames(input int n, input bit contiguous);
    int w;
    w = 0;
    while (frame_q.size() < n && w < 60 * n + 100) begin
      @(negedge clk);
      w++;
    end
    check("tx_frames_seen", 32'(frame_q.size() >= n), 1);
    for (int i = 0; i < n; i++) begin
      logic [7:0]  e;
      logic [10:0] f;
      int          g;
      if (frame_q.size() == 0 || tx_exp.size() == 0) break;
      e = tx_exp.pop_front();
      f = frame_q.pop_front();
      g = (gap_q.size() > 0) ? gap_q.pop_front() : -1;
      check("tx_frame", 32'(f), 32'({1'b0, 1'b1, e, 1'b0}));
      if (contiguous && i > 0) check("tx_gap", g, 0);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic rx_model_push(input logic [7:0] b);
    if (rx_model.size() < DEPTH) rx_model.push_back(b);
    else ovr_exp = 1'b1;
  endtask

  task automatic pop_rx();
    check("rx_ready", 32'(uart_out_ready), 32'(rx_model.size() != 0));
    if (rx_model.size() > 0) check("rx_data", 32'(uart_out_data), 32'(rx_model[0]));
    uart_out_valid = 1'b1;
    @(negedge clk);
    uart_out_valid = 1'b0;
    if (rx_model.size() > 0) void'(rx_model.pop_front());
  endtask

  initial begin : main
    int e0;
    int w;
    logic [7:0] b;
    reset = 1'b0;
    uart_in_valid = 1'b0;
    uart_out_valid = 1'b0;
    uart_in_data = 8'h00;
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(uart_in_ready), 1);
    check("rst_out_ready", 32'(uart_out_ready), 0);
    check("rst_out_data", 32'(uart_out_data), 0);
    check("rst_txd", 32'(txd), 1);
    check("rst_tx_busy", 32'(tx_busy), 0);
    check("rst_overrun", 32'(rx_overrun), 0);
    check("rst_frame_err", 32'(rx_frame_err), 0);
    do_reset();

    // Single TX with exact latency and busy timing
    push_tx(8'hA5);
    check("tx_lat_e", 32'(txd), 1);
    @(negedge clk);
    check("tx_lat_e1", 32'(txd), 0);
    check("tx_busy_on", 32'(tx_busy), 1);
    repeat (10 * CPB - 1) @(negedge clk);
    check("tx_stop_txd", 32'(txd), 1);
    check("tx_busy_stop", 32'(tx_busy), 1);
    @(negedge clk);
    check("tx_busy_fall", 32'(tx_busy), 0);
    check_tx_frames(1, 1'b0);

    // Back-to-back TX, FIFO full and refill timing
    push_tx(8'h01);
    e0 = cyc;
    for (int i = 2; i <= 5; i++) push_tx(8'(i));
    check("tx_full", 32'(uart_in_ready), 0);
    w = 0;
    while (!uart_in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("tx_rdy_ret", cyc - e0, 10 * CPB + 1);
    check_tx_frames(5, 1'b1);

    // RX then IN
    send_rx(8'h3C, 1'b1);
    check("rx_rdy_pre", 32'(uart_out_ready), 0);
    @(negedge clk);
    rx_model_push(8'h3C);
    check("rx_rdy_rise", 32'(uart_out_ready), 1);
    pop_rx();
    check("rx_rdy_fall", 32'(uart_out_ready), 0);
    check("rx_empty_data", 32'(uart_out_data), 0);

    // Overrun with no pops
    for (int i = 0; i < 5; i++) begin
      send_rx(8'(8'h10 + i), 1'b1);
      rx_model_push(8'(8'h10 + i));
    end
    repeat (2) @(negedge clk);
    check("rx_overrun_set", 32'(rx_overrun), 32'(ovr_exp));
    for (int i = 0; i < 4; i++) pop_rx();
    check("rx_drained", 32'(uart_out_ready), 0);

    // Pop on the same edge as the push into a full FIFO
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_rx(8'(8'h10 + i), 1'b1);
      rx_model_push(8'(8'h10 + i));
    end
    send_rx(8'h14, 1'b1);
    pop_rx();
    rx_model_push(8'h14);
    @(negedge clk);
    check("rx_no_overrun", 32'(rx_overrun), 32'(ovr_exp));
    for (int i = 0; i < 4; i++) pop_rx();
    check("rx_drained2", 32'(uart_out_ready), 0);

    // Glitch on rxd
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_ready", 32'(uart_out_ready), 0);
    check("glitch_ferr", 32'(rx_frame_err), 0);
    check("glitch_ovr", 32'(rx_overrun), 0);

    // Framing error followed by a long break, then a good frame
    send_rx(8'($urandom), 1'b0);
    ferr_exp = 1'b1;
    repeat (12) @(negedge clk);
    check("ferr_set", 32'(rx_frame_err), 32'(ferr_exp));
    check("ferr_no_push", 32'(uart_out_ready), 0);
    rxd = 1'b1;
    repeat (6) @(negedge clk);
    b = 8'($urandom);
    send_rx(b, 1'b1);
    repeat (2) @(negedge clk);
    rx_model_push(b);
    pop_rx();

    // Asynchronous reset mid-frame on both directions
    push_tx(8'($urandom));
    repeat (12) @(negedge clk);
    rxd = 1'b0;
    repeat (10) @(negedge clk);
    check("ferr_before_rst", 32'(rx_frame_err), 1);
    #2 reset = 1'b0;
    #1;
    check("arst_txd", 32'(txd), 1);
    check("arst_in_ready", 32'(uart_in_ready), 1);
    check("arst_out_ready", 32'(uart_out_ready), 0);
    check("arst_busy", 32'(tx_busy), 0);
    check("arst_ferr", 32'(rx_frame_err), 0);
    check("arst_ovr", 32'(rx_overrun), 0);
    rxd = 1'b1;
    do_reset();
    push_tx(8'h55);
    check_tx_frames(1, 1'b0);
    check("post_rst_rx_empty", 32'(uart_out_ready), 0);

    // Randomized TX stream with random gaps and junk data while idle
    for (int i = 0; i < 6; i++) begin
      push_tx(8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    check_tx_frames(6, 1'b0);

    // Randomized RX stream with random pops between frames
    for (int i = 0; i < 8; i++) begin
      int k;
      b = 8'($urandom);
      send_rx(b, 1'b1);
      repeat (2 + $urandom_range(0, 4)) @(negedge clk);
      rx_model_push(b);
      k = int'($urandom_range(0, 32'(rx_model.size())));
      for (int j = 0; j < k; j++) pop_rx();
    end
    check("rand_overrun", 32'(rx_overrun), 32'(ovr_exp));
    check("rand_ferr", 32'(rx_frame_err), 32'(ferr_exp));
    while (rx_model.size() > 0) pop_rx();
    check("rand_drained", 32'(uart_out_ready), 0);
    check("final_tx_idle", 32'(tx_busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
